// File: rtl/mprj_wb_responder_pkg.sv
// ----------------------------------------------------------------------------
// mprj_wb_responder_pkg
// Shared definitions for the Wishbone register responder:
//   - byte offsets of the register map inside the 256-byte window
//   - CTRL / STATUS bit positions
//   - bus FSM state encoding
//   - byte-lane merge helper used for every sel-qualified register write
// ----------------------------------------------------------------------------
package mprj_wb_responder_pkg;

    localparam logic [7:0] OFS_CTRL     = 8'h00;
    localparam logic [7:0] OFS_STATUS   = 8'h04;
    localparam logic [7:0] OFS_COUNT    = 8'h08;
    localparam logic [7:0] OFS_COMPARE  = 8'h0C;
    localparam logic [7:0] OFS_SCRATCH0 = 8'h10;
    localparam logic [7:0] OFS_SCRATCH3 = 8'h1C;

    localparam int CTRL_CNT_EN_BIT = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int STATUS_PEND_BIT = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } wb_state_e;

    // Replace only the byte lanes whose select bit is set.
    function automatic logic [31:0] merge_lanes(input logic [31:0] cur,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  sel);
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = sel[i] ? new_val[8*i +: 8] : cur[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/mprj_wb_responder_if.sv
// ----------------------------------------------------------------------------
// mprj_wb_responder_if
// Wishbone classic bus bundle between a master and the responder.
//   wb_cyc_i / wb_stb_i / wb_we_i : cycle, strobe, write (master -> slave)
//   wb_sel_i[3:0]                 : byte lane selects
//   wb_adr_i[31:0]                : byte address
//   wb_dat_i[31:0]                : write data
//   wb_ack_o                      : transfer acknowledge (slave -> master)
//   wb_dat_o[31:0]                : read data
// Signal suffixes are from the responder's point of view.
// ----------------------------------------------------------------------------
interface mprj_wb_responder_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic        wb_ack_o;
    logic [31:0] wb_dat_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
        input  wb_ack_o, wb_dat_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
        output wb_ack_o, wb_dat_o
    );
endinterface

// File: rtl/mprj_wb_timer.sv
// ----------------------------------------------------------------------------
// mprj_wb_timer
// Free-running COUNT with COMPARE match and a sticky pending flag.
//   core_clk, core_rst : clock, synchronous active-high reset
//   cnt_en_i           : count enable (CTRL.cnt_en)
//   wr_sel_i, wr_data_i: byte lanes and data of the committing bus write
//   cnt_wr_i, cmp_wr_i : bus write to COUNT / COMPARE this cycle
//   pend_clr_i         : write-1-to-clear of STATUS.pending this cycle
//   count_o, compare_o, pending_o : register values
// ----------------------------------------------------------------------------
module mprj_wb_timer
    import mprj_wb_responder_pkg::*;
(
    input  logic        core_clk,
    input  logic        core_rst,
    input  logic        cnt_en_i,
    input  logic [3:0]  wr_sel_i,
    input  logic [31:0] wr_data_i,
    input  logic        cnt_wr_i,
    input  logic        cmp_wr_i,
    input  logic        pend_clr_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        pending_o
);

    logic [31:0] count_q,   count_d;
    logic [31:0] compare_q, compare_d;
    logic        pending_q, pending_d;

    always_comb begin
        count_d   = count_q;
        compare_d = compare_q;
        pending_d = pending_q;

        // A bus write replaces the count outright; the increment is lost.
        if (cnt_wr_i) begin
            count_d = merge_lanes(count_q, wr_data_i, wr_sel_i);
        end else if (cnt_en_i) begin
            count_d = count_q + 32'd1;
        end

        if (cmp_wr_i) begin
            compare_d = merge_lanes(compare_q, wr_data_i, wr_sel_i);
        end

        // Set is evaluated last so a same-cycle match beats the clear.
        if (pend_clr_i) begin
            pending_d = 1'b0;
        end
        if (cnt_en_i && (count_q == compare_q)) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            count_q   <= '0;
            compare_q <= '0;
            pending_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            pending_q <= pending_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign pending_o = pending_q;

endmodule

// File: rtl/mprj_wb_responder.sv
// ----------------------------------------------------------------------------
// mprj_wb_responder
// Wishbone classic slave exposing CTRL/STATUS/COUNT/COMPARE/SCRATCH0-3 in a
// 256-byte window at BASE_ADR, acknowledging after WAIT_STATES extra cycles.
//   core_clk, core_rst : clock, synchronous active-high reset
//   wb                 : Wishbone slave port (mprj_wb_responder_if.slave)
//   irq_o[2:0]         : bit0 = timer pending & irq_en, bits 2:1 always 0
// ----------------------------------------------------------------------------
module mprj_wb_responder
    import mprj_wb_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADR    = 32'h3000_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic                        core_clk,
    input  logic                        core_rst,
    mprj_wb_responder_if.slave          wb,
    output logic [2:0]                  irq_o
);

    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    wb_state_e   state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;

    // Transfer attributes captured when leaving IDLE.
    logic        we_q;
    logic [3:0]  sel_q;
    logic [7:0]  ofs_q;
    logic [31:0] dat_q;

    logic [1:0]  ctrl_q;
    logic [31:0] scratch_q [4];

    logic        req_hit;
    logic        take_req;
    logic        wr_commit;
    logic        scratch_sel;
    logic [31:0] rdata;
    logic [31:0] count;
    logic [31:0] compare;
    logic        pending;
    logic        unused_adr_bits;

    assign req_hit   = wb.wb_cyc_i && wb.wb_stb_i &&
                       (wb.wb_adr_i[31:8] == BASE_ADR[31:8]);
    assign take_req  = (state_q == ST_IDLE) && req_hit;
    assign wr_commit = (state_q == ST_ACK) && we_q;
    assign scratch_sel = (ofs_q >= OFS_SCRATCH0) && (ofs_q <= OFS_SCRATCH3);
    assign unused_adr_bits = ^wb.wb_adr_i[1:0];

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_hit) begin
                    if (WAIT_STATES == 0) begin
                        state_d = ST_ACK;
                    end else begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                // Master gave up the cycle: abandon without ack or write.
                if (!wb.wb_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (wait_cnt_q == 4'd0) begin
                    state_d = ST_ACK;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            ctrl_q     <= '0;
            for (int i = 0; i < 4; i++) begin
                scratch_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (wr_commit && (ofs_q == OFS_CTRL) && sel_q[0]) begin
                ctrl_q <= dat_q[1:0];
            end
            if (wr_commit && scratch_sel) begin
                scratch_q[ofs_q[3:2]] <= merge_lanes(scratch_q[ofs_q[3:2]], dat_q, sel_q);
            end
        end
    end

    always_ff @(posedge core_clk) begin
        if (take_req) begin
            we_q  <= wb.wb_we_i;
            sel_q <= wb.wb_sel_i;
            ofs_q <= {wb.wb_adr_i[7:2], 2'b00};
            dat_q <= wb.wb_dat_i;
        end
    end

    mprj_wb_timer u_timer (
        .core_clk   (core_clk),
        .core_rst   (core_rst),
        .cnt_en_i   (ctrl_q[CTRL_CNT_EN_BIT]),
        .wr_sel_i   (sel_q),
        .wr_data_i  (dat_q),
        .cnt_wr_i   (wr_commit && (ofs_q == OFS_COUNT)),
        .cmp_wr_i   (wr_commit && (ofs_q == OFS_COMPARE)),
        .pend_clr_i (wr_commit && (ofs_q == OFS_STATUS) && sel_q[0] && dat_q[STATUS_PEND_BIT]),
        .count_o    (count),
        .compare_o  (compare),
        .pending_o  (pending)
    );

    // Offsets 0x20-0xFC fall through to 0.
    always_comb begin
        rdata = '0;
        if (scratch_sel) begin
            rdata = scratch_q[ofs_q[3:2]];
        end else begin
            case (ofs_q)
                OFS_CTRL:    rdata = {30'd0, ctrl_q};
                OFS_STATUS:  rdata = {31'd0, pending};
                OFS_COUNT:   rdata = count;
                OFS_COMPARE: rdata = compare;
                default:     rdata = '0;
            endcase
        end
    end

    assign wb.wb_ack_o = (state_q == ST_ACK);
    assign wb.wb_dat_o = (state_q == ST_ACK) ? rdata : '0;
    assign irq_o       = {2'b00, pending & ctrl_q[CTRL_IRQ_EN_BIT]};

endmodule

// File: doc/mprj_wb_responder.md
MPRJ_WB_RESPONDER -- requirements
Module: mprj_wb_responder

Interface
REQ-001 SHALL have parameter BASE_ADR, default 32'h3000_0000: byte base of the 256-byte responder window.
REQ-002 SHALL have parameter WAIT_STATES, default 1, range 0..15: extra cycles inserted before ack.
REQ-003 SHALL have port core_clk, input, 1 bit: single clock; all logic rises on it.
REQ-004 SHALL have port core_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have ports wb_cyc_i, wb_stb_i and wb_we_i, each input, 1 bit: Wishbone classic cycle, strobe and write.
REQ-006 SHALL have port wb_sel_i, input, 4 bits: byte lane selects.
REQ-007 SHALL have ports wb_adr_i and wb_dat_i, each input, 32 bits: byte address and write data.
REQ-008 SHALL have port wb_ack_o, output, 1 bit: transfer acknowledge.
REQ-009 SHALL have port wb_dat_o, output, 32 bits: read data.
REQ-010 SHALL have port irq_o, output, 3 bits: bit0 timer match; bits 2:1 tied 0.

Function
REQ-011 SHALL decode a hit as wb_adr_i[31:8]==BASE_ADR[31:8]; offset = wb_adr_i[7:2].
REQ-012 SHALL implement register map:
- 0x00 CTRL RW: bit0 cnt_en, bit1 irq_en; other bits read 0.
- 0x04 STATUS: bit0 pending; write-1-to-clear.
- 0x08 COUNT RW.
- 0x0C COMPARE RW.
- 0x10-0x1C SCRATCH0-3 RW.
REQ-013 SHALL run FSM states:
- IDLE -> WAIT when cyc&stb&hit and WAIT_STATES>0.
- IDLE -> ACK when cyc&stb&hit and WAIT_STATES==0.
- WAIT -> ACK after WAIT_STATES cycles.
- ACK -> IDLE unconditionally.
REQ-014 SHALL assert wb_ack_o only in ACK, exactly one cycle per transfer; request sampled at edge N gives ack high in cycle N+1+WAIT_STATES.
REQ-015 SHALL latch we, sel, offset and write data on entry from IDLE.
REQ-016 SHALL commit a write at the ACK cycle, per byte lane enabled by sel.
REQ-017 SHALL drive wb_dat_o with the addressed register during ACK and 0 otherwise.
REQ-018 SHALL ack in-window offsets 0x20-0xFC with read data 0 and ignore writes to them.
REQ-019 SHALL give no response to out-of-window addresses: no ack, no state change.
REQ-020 SHALL abort if wb_cyc_i drops in WAIT: go to IDLE, no ack, no write.
REQ-021 SHALL increment COUNT by 1 per cycle while cnt_en=1, wrapping 0xFFFF_FFFF -> 0.
REQ-022 SHALL let a bus write to COUNT win over a same-cycle increment.
REQ-023 SHALL set pending on the cycle COUNT==COMPARE while cnt_en=1.
REQ-024 SHALL let set win over a same-cycle W1C.
REQ-025 SHALL drive irq_o[0] = pending & irq_en, registered-free combinational AND of flops.

Reset
REQ-026 SHALL on core_rst=1 at a clock edge set FSM to IDLE and clear CTRL, STATUS, COUNT, COMPARE and SCRATCH0-3 to 0.
REQ-027 SHALL hold wb_ack_o=0, wb_dat_o=0 and irq_o=0 during and after reset until a new transfer.
REQ-028 SHALL drop any in-flight transfer on mid-operation reset: no ack, no write.

Structure
REQ-029 SHALL put register offsets, CTRL/STATUS bit positions and the FSM state encoding in package mprj_wb_responder_pkg.
REQ-030 SHALL place COUNT/COMPARE/pending logic in sub-module mprj_wb_timer; the bus FSM and decode stay in the top.

Verification
REQ-031 SHALL check write-then-read: write 0xDEADBEEF to 0x3000_0010, sel=4'hF, WAIT_STATES=1 -> ack 2 cycles after request; read returns 0xDEADBEEF.
REQ-032 SHALL check byte lanes: SCRATCH1=0x11223344, then write 0xAABBCCDD with sel=4'b0101 -> read 0x11BB33DD.
REQ-033 SHALL check timer: COMPARE=5, CTRL=0x3 -> irq_o[0] rises about 5 cycles later; write 1 to STATUS -> irq_o[0]=0.
REQ-034 SHALL check decode: access to 0x3000_0100 -> no ack for 20 cycles; read of 0x3000_0040 -> ack with data 0.
REQ-035 SHALL check abort: drop cyc in WAIT with WAIT_STATES=3 on a write to COMPARE -> no ack, COMPARE unchanged.
REQ-036 SHALL check reset: assert core_rst during WAIT -> ack never asserts; all registers read 0 afterward.
